// File: rtl/godai_mem_arbiter.sv
// godai_mem_arbiter
// Shares one req/gnt/rvalid memory port between an instruction requester and
// a data requester, with at most one transaction outstanding at a time.
//
// Ports
//   clk, rst        : single clock; asynchronous active-high reset
//   instr_*         : instruction requester (read-only): req/addr in, gnt/rvalid/rdata out
//   data_*          : data requester: req/addr/we/be/wdata in, gnt/rvalid/rdata/err out
//   mem_*           : shared memory port: req/addr/we/be/wdata out, gnt/rvalid/rdata/err in
//   busy_o          : arbiter is not idle
//   protocol_err_o  : one-cycle registered pulse after an unexpected mem_rvalid_i
module godai_mem_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  instr_req_i,
  input  logic [ADDR_WIDTH-1:0] instr_addr_i,
  output logic                  instr_gnt_o,
  output logic                  instr_rvalid_o,
  output logic [DATA_WIDTH-1:0] instr_rdata_o,
  input  logic                  data_req_i,
  input  logic [ADDR_WIDTH-1:0] data_addr_i,
  input  logic                  data_we_i,
  input  logic [3:0]            data_be_i,
  input  logic [DATA_WIDTH-1:0] data_wdata_i,
  output logic                  data_gnt_o,
  output logic                  data_rvalid_o,
  output logic [DATA_WIDTH-1:0] data_rdata_o,
  output logic                  data_err_o,
  output logic                  mem_req_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic                  mem_we_o,
  output logic [3:0]            mem_be_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  input  logic                  mem_gnt_i,
  input  logic                  mem_rvalid_i,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  input  logic                  mem_err_i,
  output logic                  busy_o,
  output logic                  protocol_err_o
);

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    WAIT_GNT    = 2'd1,
    WAIT_RVALID = 2'd2
  } state_t;

  typedef enum logic {
    OWN_INSTR = 1'b0,
    OWN_DATA  = 1'b1
  } owner_t;

  state_t state_q, state_d;
  owner_t owner_q, owner_d;
  owner_t last_owner_q, last_owner_d;
  logic   protocol_err_q, protocol_err_d;

  owner_t winner;
  owner_t sel_owner;
  logic   sel_req;
  logic   req_active;
  logic   gnt;
  logic   rvalid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      owner_q        <= OWN_INSTR;
      last_owner_q   <= OWN_DATA;
      protocol_err_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      owner_q        <= owner_d;
      last_owner_q   <= last_owner_d;
      protocol_err_q <= protocol_err_d;
    end
  end

  always_comb begin
    // Round-robin tie break: on contention the side that did not win last time goes.
    winner = OWN_INSTR;
    if (instr_req_i && data_req_i) begin
      winner = (last_owner_q == OWN_INSTR) ? OWN_DATA : OWN_INSTR;
    end else if (data_req_i) begin
      winner = OWN_DATA;
    end

    // In IDLE the memory port follows the live winner; afterwards it is frozen on the owner.
    sel_owner = (state_q == IDLE) ? winner : owner_q;
    sel_req   = (sel_owner == OWN_INSTR) ? instr_req_i : data_req_i;

    req_active = ((state_q == IDLE) || (state_q == WAIT_GNT)) && sel_req;
    mem_req_o  = req_active && !rst;
    gnt        = mem_req_o && mem_gnt_i;
    rvalid     = (state_q == WAIT_RVALID) && mem_rvalid_i && !rst;

    if (sel_owner == OWN_INSTR) begin
      mem_addr_o  = instr_addr_i;
      mem_we_o    = 1'b0;
      mem_be_o    = 4'b1111;
      mem_wdata_o = '0;
    end else begin
      mem_addr_o  = data_addr_i;
      mem_we_o    = data_we_i;
      mem_be_o    = data_be_i;
      mem_wdata_o = data_wdata_i;
    end

    instr_gnt_o    = gnt && (sel_owner == OWN_INSTR);
    data_gnt_o     = gnt && (sel_owner == OWN_DATA);
    instr_rvalid_o = rvalid && (owner_q == OWN_INSTR);
    data_rvalid_o  = rvalid && (owner_q == OWN_DATA);
    instr_rdata_o  = instr_rvalid_o ? mem_rdata_i : '0;
    data_rdata_o   = data_rvalid_o ? mem_rdata_i : '0;
    data_err_o     = data_rvalid_o && mem_err_i;

    busy_o         = (state_q != IDLE);
    protocol_err_o = protocol_err_q;
  end

  always_comb begin
    state_d        = state_q;
    owner_d        = owner_q;
    last_owner_d   = last_owner_q;
    // A response with nothing outstanding is dropped and flagged.
    protocol_err_d = mem_rvalid_i && (state_q != WAIT_RVALID);
    unique case (state_q)
      IDLE: begin
        if (req_active) begin
          owner_d = winner;
          if (mem_gnt_i) begin
            state_d      = WAIT_RVALID;
            last_owner_d = winner;
          end else begin
            state_d = WAIT_GNT;
          end
        end
      end
      WAIT_GNT: begin
        // Owner withdrew before grant: abandon without crediting it in round-robin.
        if (!req_active) begin
          state_d = IDLE;
        end else if (mem_gnt_i) begin
          state_d      = WAIT_RVALID;
          last_owner_d = owner_q;
        end
      end
      WAIT_RVALID: begin
        if (mem_rvalid_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_godai_mem_arbiter.sv
module tb_godai_mem_arbiter;

  logic        clk;
  logic        rst;
  logic        instr_req_i;
  logic [31:0] instr_addr_i;
  logic        instr_gnt_o;
  logic        instr_rvalid_o;
  logic [31:0] instr_rdata_o;
  logic        data_req_i;
  logic [31:0] data_addr_i;
  logic        data_we_i;
  logic [3:0]  data_be_i;
  logic [31:0] data_wdata_i;
  logic        data_gnt_o;
  logic        data_rvalid_o;
  logic [31:0] data_rdata_o;
  logic        data_err_o;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_we_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_wdata_o;
  logic        mem_gnt_i;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;
  logic        mem_err_i;
  logic        busy_o;
  logic        protocol_err_o;

  int checks = 0;
  int errors = 0;

  godai_mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk            (clk),
    .rst            (rst),
    .instr_req_i    (instr_req_i),
    .instr_addr_i   (instr_addr_i),
    .instr_gnt_o    (instr_gnt_o),
    .instr_rvalid_o (instr_rvalid_o),
    .instr_rdata_o  (instr_rdata_o),
    .data_req_i     (data_req_i),
    .data_addr_i    (data_addr_i),
    .data_we_i      (data_we_i),
    .data_be_i      (data_be_i),
    .data_wdata_i   (data_wdata_i),
    .data_gnt_o     (data_gnt_o),
    .data_rvalid_o  (data_rvalid_o),
    .data_rdata_o   (data_rdata_o),
    .data_err_o     (data_err_o),
    .mem_req_o      (mem_req_o),
    .mem_addr_o     (mem_addr_o),
    .mem_we_o       (mem_we_o),
    .mem_be_o       (mem_be_o),
    .mem_wdata_o    (mem_wdata_o),
    .mem_gnt_i      (mem_gnt_i),
    .mem_rvalid_i   (mem_rvalid_i),
    .mem_rdata_i    (mem_rdata_i),
    .mem_err_i      (mem_err_i),
    .busy_o         (busy_o),
    .protocol_err_o (protocol_err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled 1 time unit later.
  task automatic nxt;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    instr_req_i = 1'b1; instr_addr_i = 32'h40;
    data_req_i = 1'b0; data_addr_i = 32'h200; data_we_i = 1'b0;
    data_be_i = 4'hF; data_wdata_i = 32'h0;
    mem_gnt_i = 1'b1; mem_rvalid_i = 1'b0; mem_rdata_i = 32'h0; mem_err_i = 1'b0;

    // Reset before any clock edge: outputs quiet even with a request and grant pending.
    #3;
    chk("rst_mem_req", mem_req_o, 0);
    chk("rst_instr_gnt", instr_gnt_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_perr", protocol_err_o, 0);

    // Both request on the first idle cycle: instruction wins (last_owner resets to data).
    nxt; rst = 1'b0; data_req_i = 1'b1; #1;
    chk("rr1_instr_gnt", instr_gnt_o, 1);
    chk("rr1_data_gnt", data_gnt_o, 0);
    chk("rr1_mem_addr", mem_addr_o, 32'h40);
    chk("rr1_mem_we", mem_we_o, 0);
    chk("rr1_mem_be", mem_be_o, 4'hF);
    chk("rr1_mem_wdata", mem_wdata_o, 0);
    chk("rr1_mem_req", mem_req_o, 1);

    // WAIT_RVALID: no request to memory, no grant even though mem_gnt_i is high.
    nxt; #1;
    chk("wr_mem_req", mem_req_o, 0);
    chk("wr_instr_gnt", instr_gnt_o, 0);
    chk("wr_data_gnt", data_gnt_o, 0);
    chk("wr_busy", busy_o, 1);
    nxt; mem_rvalid_i = 1'b1; mem_rdata_i = 32'h11; #1;
    chk("rr1_instr_rvalid", instr_rvalid_o, 1);
    chk("rr1_instr_rdata", instr_rdata_o, 32'h11);
    chk("rr1_data_rvalid", data_rvalid_o, 0);
    chk("rr1_data_rdata", data_rdata_o, 0);

    // Next free cycle: data wins the round-robin.
    nxt; mem_rvalid_i = 1'b0; #1;
    chk("rr2_data_gnt", data_gnt_o, 1);
    chk("rr2_instr_gnt", instr_gnt_o, 0);
    chk("rr2_mem_addr", mem_addr_o, 32'h200);
    chk("rr2_busy", busy_o, 0);

    // Data read completes with an error response.
    nxt; instr_req_i = 1'b0; data_req_i = 1'b0;
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'hDEAD0001; mem_err_i = 1'b1; #1;
    chk("err_data_rvalid", data_rvalid_o, 1);
    chk("err_data_rdata", data_rdata_o, 32'hDEAD0001);
    chk("err_data_err", data_err_o, 1);
    chk("err_instr_rvalid", instr_rvalid_o, 0);
    nxt; mem_rvalid_i = 1'b0; mem_err_i = 1'b0; #1;
    chk("err_gone", data_err_o, 0);
    chk("err_idle_busy", busy_o, 0);
    chk("err_no_perr", protocol_err_o, 0);

    // Data write with grant held off for three WAIT_GNT cycles.
    nxt; mem_gnt_i = 1'b0; data_req_i = 1'b1; data_addr_i = 32'h100;
    data_we_i = 1'b1; data_be_i = 4'b0011; data_wdata_i = 32'hBD8528BE; #1;
    chk("wg0_mem_req", mem_req_o, 1);
    chk("wg0_data_gnt", data_gnt_o, 0);
    for (int i = 0; i < 3; i++) begin
      nxt; instr_req_i = 1'b1; #1;
      chk("wg_busy", busy_o, 1);
      chk("wg_mem_req", mem_req_o, 1);
      chk("wg_mem_addr", mem_addr_o, 32'h100);
      chk("wg_mem_we", mem_we_o, 1);
      chk("wg_mem_be", mem_be_o, 4'b0011);
      chk("wg_mem_wdata", mem_wdata_o, 32'hBD8528BE);
      chk("wg_data_gnt", data_gnt_o, 0);
      chk("wg_instr_gnt", instr_gnt_o, 0);
    end
    nxt; mem_gnt_i = 1'b1; #1;
    chk("wg4_data_gnt", data_gnt_o, 1);
    chk("wg4_instr_gnt", instr_gnt_o, 0);
    chk("wg4_busy", busy_o, 1);
    nxt; instr_req_i = 1'b0; data_req_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 32'h0; #1;
    chk("wg_rvalid", data_rvalid_o, 1);
    chk("wg_err", data_err_o, 0);

    // Instruction read, response two cycles after grant.
    nxt; mem_rvalid_i = 1'b0; instr_req_i = 1'b1; instr_addr_i = 32'h80;
    data_we_i = 1'b0; data_be_i = 4'hF; #1;
    chk("ir_instr_gnt", instr_gnt_o, 1);
    chk("ir_mem_addr", mem_addr_o, 32'h80);
    nxt; instr_req_i = 1'b0; #1;
    chk("ir_wait_rvalid", instr_rvalid_o, 0);
    nxt; mem_rvalid_i = 1'b1; mem_rdata_i = 32'h0000006F; #1;
    chk("ir_instr_rvalid", instr_rvalid_o, 1);
    chk("ir_instr_rdata", instr_rdata_o, 32'h6F);
    chk("ir_data_rvalid", data_rvalid_o, 0);
    nxt; mem_rvalid_i = 1'b0; #1;
    chk("ir_idle_busy", busy_o, 0);

    // Data request withdrawn in WAIT_GNT: abandoned, last_owner stays instruction.
    nxt; mem_gnt_i = 1'b0; data_req_i = 1'b1; data_addr_i = 32'h300; #1;
    chk("ab_mem_req0", mem_req_o, 1);
    nxt; data_req_i = 1'b0; #1;
    chk("ab_mem_req", mem_req_o, 0);
    chk("ab_busy", busy_o, 1);
    nxt; #1;
    chk("ab_idle", busy_o, 0);
    nxt; instr_req_i = 1'b1; data_req_i = 1'b1; mem_gnt_i = 1'b1; #1;
    chk("ab_data_wins", data_gnt_o, 1);
    chk("ab_instr_lose", instr_gnt_o, 0);
    nxt; instr_req_i = 1'b0; data_req_i = 1'b0; mem_rvalid_i = 1'b1; #1;
    chk("ab_rvalid", data_rvalid_o, 1);

    // Stray response in IDLE: dropped, flagged one cycle later for one cycle.
    nxt; mem_rvalid_i = 1'b1; mem_rdata_i = 32'h55; #1;
    chk("pe_instr_rvalid", instr_rvalid_o, 0);
    chk("pe_data_rvalid", data_rvalid_o, 0);
    chk("pe_now", protocol_err_o, 0);
    nxt; mem_rvalid_i = 1'b0; #1;
    chk("pe_pulse", protocol_err_o, 1);
    nxt; #1;
    chk("pe_clear", protocol_err_o, 0);

    // Reset asserted between edges while in WAIT_RVALID.
    nxt; instr_req_i = 1'b1; #1;
    chk("mr_instr_gnt", instr_gnt_o, 1);
    nxt; #1;
    chk("mr_busy_before", busy_o, 1);
    #2; rst = 1'b1; mem_rvalid_i = 1'b1; #1;
    chk("mr_busy", busy_o, 0);
    chk("mr_mem_req", mem_req_o, 0);
    chk("mr_instr_rvalid", instr_rvalid_o, 0);
    chk("mr_instr_gnt2", instr_gnt_o, 0);
    nxt; #1;
    chk("mr_perr_held", protocol_err_o, 0);
    // Late response after reset release is a protocol error.
    nxt; rst = 1'b0; instr_req_i = 1'b0; #1;
    chk("mr_late_rvalid", instr_rvalid_o, 0);
    nxt; mem_rvalid_i = 1'b0; #1;
    chk("mr_late_perr", protocol_err_o, 1);
    // Both served in order instruction then data.
    nxt; instr_req_i = 1'b1; data_req_i = 1'b1; #1;
    chk("mr_rr_instr", instr_gnt_o, 1);
    chk("mr_rr_data0", data_gnt_o, 0);
    nxt; mem_rvalid_i = 1'b1; #1;
    chk("mr_rr_rvalid", instr_rvalid_o, 1);
    nxt; mem_rvalid_i = 1'b0; #1;
    chk("mr_rr_data", data_gnt_o, 1);
    chk("mr_rr_instr0", instr_gnt_o, 0);

    nxt; instr_req_i = 1'b0; data_req_i = 1'b0; mem_gnt_i = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/godai_mem_arbiter.md
GODAI_MEM_ARBITER -- requirements
Module: godai_mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, address width of all ports.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, data width of all ports.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have instruction-side ports instr_req_i in 1, instr_addr_i in ADDR_WIDTH, instr_gnt_o out 1, instr_rvalid_o out 1, instr_rdata_o out DATA_WIDTH.
REQ-006 SHALL have data-side ports data_req_i in 1, data_addr_i in ADDR_WIDTH, data_we_i in 1, data_be_i in 4, data_wdata_i in DATA_WIDTH, data_gnt_o out 1, data_rvalid_o out 1, data_rdata_o out DATA_WIDTH, data_err_o out 1.
REQ-007 SHALL have memory-side ports mem_req_o out 1, mem_addr_o out ADDR_WIDTH, mem_we_o out 1, mem_be_o out 4, mem_wdata_o out DATA_WIDTH, mem_gnt_i in 1, mem_rvalid_i in 1, mem_rdata_i in DATA_WIDTH, mem_err_i in 1.
REQ-008 SHALL have status ports busy_o out 1 (state not IDLE) and protocol_err_o out 1 (registered one-cycle pulse on an unexpected mem_rvalid_i).

Function
REQ-009 SHALL share one memory port between instruction and data requesters using req/gnt/rvalid protocol; at most one transaction outstanding.
REQ-010 SHALL implement states IDLE, WAIT_GNT, WAIT_RVALID; owner register (INSTR/DATA); last_owner register.
REQ-011 IDLE: no request -> stay; one request -> that requester wins; both -> requester not equal to last_owner wins (round-robin).
REQ-012 Winner selection in IDLE SHALL be combinational: mem_req_o and mem_* fields driven from winner in same cycle as its req.
REQ-013 Instruction transactions SHALL drive mem_we_o=0, mem_be_o=4'b1111, mem_wdata_o=0.
REQ-014 mem_gnt_i=1 while mem_req_o=1 SHALL assert winner/owner gnt_o combinationally same cycle; next state WAIT_RVALID; owner and last_owner updated to winner.
REQ-015 mem_gnt_i=0 in IDLE with request -> next state WAIT_GNT, owner latched; arbitration frozen until grant.
REQ-016 WAIT_GNT: mem_req_o and mem_* fields follow owner's inputs; grant -> WAIT_RVALID; owner req_i deasserted -> mem_req_o=0, return to IDLE, last_owner unchanged.
REQ-017 WAIT_RVALID: mem_req_o=0; mem_rvalid_i=1 -> owner rvalid_o=1 and rdata_o=mem_rdata_i same cycle, data_err_o=mem_err_i if owner DATA; next state IDLE.
REQ-018 New arbitration SHALL start the cycle after rvalid (minimum 3-cycle-per-transaction back-to-back spacing not required: grant may occur first IDLE cycle).
REQ-019 Non-owner gnt_o/rvalid_o SHALL be 0 at all times; rdata_o of non-owner SHALL be 0; data_err_o=0 except REQ-017.
REQ-020 mem_rvalid_i=1 in IDLE or WAIT_GNT SHALL be ignored (not forwarded) and raise protocol_err_o next cycle for one cycle.
REQ-021 gnt_o SHALL never be asserted while the arbiter is in WAIT_RVALID.

Reset
REQ-022 rst=1 SHALL immediately force state IDLE, owner=INSTR, last_owner=DATA, protocol_err_o=0, busy_o=0, without waiting for clk.
REQ-023 While rst=1 mem_req_o and all gnt_o/rvalid_o SHALL be 0.
REQ-024 Reset mid-transaction SHALL abandon it; late mem_rvalid_i after reset is handled per REQ-020.

Verification
REQ-025 Both req high at first IDLE cycle after reset, mem_gnt_i=1 -> instr_gnt_o=1 same cycle, data_gnt_o=0; next free cycle data wins.
REQ-026 Data write addr 0x100, be 4'b0011, wdata 0xBD8528BE, mem_gnt_i delayed 3 cycles -> mem_* stable 3 cycles in WAIT_GNT, data_gnt_o on 4th, busy_o high throughout.
REQ-027 Instr read, mem_rvalid_i with rdata 0x0000006F two cycles after grant -> instr_rvalid_o=1, instr_rdata_o=0x6F that cycle, data_rvalid_o=0, state IDLE next.
REQ-028 Data read with mem_err_i=1 at rvalid -> data_err_o=1 for exactly that cycle.
REQ-029 mem_rvalid_i pulse in IDLE -> no rvalid_o, protocol_err_o=1 one cycle later for one cycle.
REQ-030 rst asserted between clk edges in WAIT_RVALID -> mem_req_o=0, busy_o=0 immediately; after release both requesters served in round-robin order instr, data.
